exp_engine: RTL and testbench



---
 rtl/exp_engine.sv | 144 ++++++++++++++
 tb/tb_exp_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/exp_engine.sv
// -----------------------------------------------------------------------------
// exp_engine
//   Iterative fixed-point exponential: y = e^x for unsigned Q0.16 x in [0, 1).
//   The result is a truncated Taylor series of N_TERMS terms. One shared
//   multiplier is used, and each term takes two multiply cycles: one by x and
//   one by the reciprocal coefficient 1/k. This block is the responder side of
//   a start/done handshake. done is high while idle (result held), low while
//   computing, and rises together with the new result.
//
// Parameters
//   N_TERMS  number of series terms summed (term_0 .. term_{N_TERMS-1}), 2..16
//
// Ports
//   clk    clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   start  level request, sampled only while idle
//   x      operand, unsigned Q0.16, captured when start is accepted
//   done   1 = idle with a valid/held result, 0 = computing
//   y      result, unsigned Q2.16, updated only at completion
// -----------------------------------------------------------------------------
module exp_engine #(
   parameter int N_TERMS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] x,
   output logic        done,
   output logic [17:0] y
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL_X = 2'd1,
      MUL_C = 2'd2,
      FINAL = 2'd3
   } state_t;

   // k value of the last series multiply; the next step is the final sum
   localparam logic [3:0] K_LAST = 4'(N_TERMS - 1);

   state_t      state_r;
   logic [15:0] x_r;
   logic [16:0] term_r;    // Q1.16, never exceeds 1.0
   logic [17:0] acc_r;     // Q2.16 running sum
   logic [3:0]  k_r;

   logic [16:0] coef_s;
   logic [16:0] mul_b_s;
   logic [32:0] prod_s;
   logic [16:0] prod_q_s;

   // Reciprocal ROM: floor(65536 / k) in Q1.16, k = 1..15
   function automatic logic [16:0] coef_rom(input logic [3:0] k);
      logic [16:0] c;
      case (k)
         4'd1:    c = 17'd65536;
         4'd2:    c = 17'd32768;
         4'd3:    c = 17'd21845;
         4'd4:    c = 17'd16384;
         4'd5:    c = 17'd13107;
         4'd6:    c = 17'd10922;
         4'd7:    c = 17'd9362;
         4'd8:    c = 17'd8192;
         4'd9:    c = 17'd7281;
         4'd10:   c = 17'd6553;
         4'd11:   c = 17'd5957;
         4'd12:   c = 17'd5461;
         4'd13:   c = 17'd5041;
         4'd14:   c = 17'd4681;
         4'd15:   c = 17'd4369;
         default: c = 17'd0;
      endcase
      return c;
   endfunction

   // Shared multiplier: term times x in MUL_X, term times 1/k otherwise.
   // Both operands are at most 0x10000, so the product fits in 33 bits.
   // Dropping 16 LSBs then yields the same 17-bit slice in both cases.
   always_comb begin
      coef_s = coef_rom(k_r);
      if (state_r == MUL_X) begin
         mul_b_s = {1'b0, x_r};
      end else begin
         mul_b_s = coef_s;
      end
      prod_s   = {16'd0, term_r} * {16'd0, mul_b_s};
      prod_q_s = 17'(prod_s >> 16);
   end

   // Control FSM and datapath registers, with registered done/y
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         x_r     <= 16'd0;
         term_r  <= 17'd0;
         acc_r   <= 18'd0;
         k_r     <= 4'd0;
         done    <= 1'b1;
         y       <= 18'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  x_r     <= x;
                  term_r  <= 17'h10000;
                  acc_r   <= 18'd0;
                  k_r     <= 4'd1;
                  done    <= 1'b0;
                  state_r <= MUL_X;
               end else begin
                  done    <= 1'b1;
                  state_r <= IDLE;
               end
            end
            MUL_X: begin
               acc_r   <= acc_r + {1'b0, term_r};
               term_r  <= prod_q_s;
               state_r <= MUL_C;
            end
            MUL_C: begin
               term_r <= prod_q_s;
               if (k_r == K_LAST) begin
                  state_r <= FINAL;
               end else begin
                  k_r     <= k_r + 4'd1;
                  state_r <= MUL_X;
               end
            end
            FINAL: begin
               // The last term is added directly into the published result
               y       <= acc_r + {1'b0, term_r};
               done    <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               done    <= 1'b1;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exp_engine.sv
// -----------------------------------------------------------------------------
// tb_exp_engine
//   Self-checking bench for exp_engine. A transaction-level model predicts
//   done/y from the handshake rules and a plain-arithmetic series evaluation.
//   A per-cycle compare process checks the DUT against that model. Directed
//   tests add literal expectations for latency, known results and reset
//   behaviour.
// -----------------------------------------------------------------------------
module tb_exp_engine;

   localparam int N       = 8;
   localparam int LAT_LOW = 2 * N - 1;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] x;
   logic        done;
   logic [17:0] y;

   int n_cmp;
   int n_err;
   bit chk_en;

   // model state
   int          m_left;     // edges remaining until completion, 0 = idle
   logic        m_done;
   logic [17:0] m_y;
   logic [15:0] m_x;

   exp_engine #(.N_TERMS(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .done  (done),
      .y     (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // e^x as the truncated series, evaluated with plain integer arithmetic
   function automatic logic [17:0] exp_model(input logic [15:0] xv);
      longint term;
      longint acc;
      longint xl;
      xl   = longint'(xv);
      term = 65536;
      acc  = 0;
      for (int k = 1; k < N; k++) begin
         acc  = acc + term;
         term = (term * xl) >> 16;
         term = ((term * longint'(65536 / k)) >> 16) % 131072;
      end
      return 18'(acc + term);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Handshake-level model, advanced on each rising edge
   always @(posedge clk) begin
      if (rst) begin
         m_left <= 0;
         m_done <= 1'b1;
         m_y    <= 18'd0;
      end else if (m_left == 0) begin
         if (start) begin
            m_left <= LAT_LOW;
            m_done <= 1'b0;
            m_x    <= x;
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_done <= 1'b1;
            m_y    <= exp_model(m_x);
         end
      end
   end

   // Per-cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_done", {31'd0, done}, {31'd0, m_done});
         check("cyc_y", {14'd0, y}, {14'd0, m_y});
      end
   end

   // Count negedges with done low, starting at the current negedge
   task automatic measure_low(output int low);
      int guard;
      low   = 0;
      guard = 0;
      while (done == 1'b0 && guard < 100) begin
         low++;
         guard++;
         @(negedge clk);
      end
   endtask

   task automatic pulse_start(input logic [15:0] xv);
      start = 1'b1;
      x     = xv;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int          low;
      int          gap;
      int          toggles;
      logic [15:0] xv;
      logic [17:0] yv;

      n_cmp  = 0;
      n_err  = 0;
      chk_en = 1'b0;
      rst    = 1'b1;
      start  = 1'b0;
      x      = 16'd0;

      // pin the model against hand-computed values
      check("model_x0", {14'd0, exp_model(16'h0000)}, 32'h10000);
      check("model_x8000", {14'd0, exp_model(16'h8000)}, 32'h1A610);

      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      rst    = 1'b0;
      check("reset_done", {31'd0, done}, 32'd1);
      check("reset_y", {14'd0, y}, 32'd0);

      // idle with start low
      toggles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done !== 1'b1 || y !== 18'd0) toggles++;
      end
      check("idle_hold", toggles, 32'd0);

      // x = 0 with a one-cycle pulse
      pulse_start(16'h0000);
      measure_low(low);
      check("x0_low_cycles", low, LAT_LOW);
      check("x0_y", {14'd0, y}, 32'h10000);

      // x = 0x8000, start held until done falls; x changes while busy
      start = 1'b1;
      x     = 16'h8000;
      @(negedge clk);
      start = 1'b0;
      x     = 16'hFFFF;
      measure_low(low);
      check("x8000_low_cycles", low, LAT_LOW);
      check("x8000_y", {14'd0, y}, 32'h1A610);

      // x = 0xFFFF then back-to-back 0x4000 with start held
      @(negedge clk);
      start = 1'b1;
      x     = 16'hFFFF;
      @(negedge clk);
      x     = 16'h4000;
      measure_low(low);
      check("xffff_low_cycles", low, LAT_LOW);
      yv = y;
      check("xffff_range", {31'd0, (yv >= 18'h2B7B0) && (yv <= 18'h2B7E1)}, 32'd1);
      check("xffff_y", {14'd0, yv}, {14'd0, exp_model(16'hFFFF)});
      gap = 0;
      while (done == 1'b1 && gap < 100) begin
         @(negedge clk);
         gap++;
      end
      start = 1'b0;
      while (done == 1'b0 && gap < 100) begin
         @(negedge clk);
         gap++;
      end
      check("b2b_gap", gap, 2 * N);
      check("x4000_y", {14'd0, y}, {14'd0, exp_model(16'h4000)});

      // mid-computation reset at busy cycle 6
      @(negedge clk);
      pulse_start(16'h8000);
      for (int i = 0; i < 5; i++) @(negedge clk);
      check("midrst_busy", {31'd0, done}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_done", {31'd0, done}, 32'd1);
      check("midrst_y", {14'd0, y}, 32'd0);
      toggles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done !== 1'b1) toggles++;
      end
      check("midrst_quiet", toggles, 32'd0);

      // rst and start on the same edge: start is not accepted
      start = 1'b1;
      rst   = 1'b1;
      x     = 16'h1234;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      check("rst_wins", {31'd0, done}, 32'd1);

      // sweep of 200 operands, including the extremes
      for (int i = 0; i < 200; i++) begin
         if (i == 0) xv = 16'h0001;
         else if (i == 1) xv = 16'hFFFE;
         else xv = 16'($urandom_range(0, 65535));
         pulse_start(xv);
         measure_low(low);
         check("sweep_low_cycles", low, LAT_LOW);
         check("sweep_y", {14'd0, y}, {14'd0, exp_model(xv)});
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
